// File: rtl/ps2_quad_pkg.sv
// Shared constants for the PS/2 mouse to quadrature emulator: output modes,
// status-byte bit positions, overflow substitution values and delta decode.
package ps2_quad_pkg;

   localparam int MODE_QUAD    = 0;
   localparam int MODE_STEPDIR = 1;

   // Status byte layout: YOVR, XOVR, YSGN, XSGN, 1, M, R, L
   localparam int ST_L    = 0;
   localparam int ST_R    = 1;
   localparam int ST_M    = 2;
   localparam int ST_ONE  = 3;
   localparam int ST_XSGN = 4;
   localparam int ST_YSGN = 5;
   localparam int ST_XOVR = 6;
   localparam int ST_YOVR = 7;

   // Values substituted for a delta whose overflow bit is set
   localparam int OVR_POS = 255;
   localparam int OVR_NEG = -256;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_POS,
      STEP_NEG
   } step_e;

   // 9-bit signed delta from sign bit and magnitude byte, with overflow clamp
   function automatic logic signed [8:0] decode_delta(input logic       sgn,
                                                      input logic       ovr,
                                                      input logic [7:0] mag);
      if (ovr) begin
         return sgn ? 9'(OVR_NEG) : 9'(OVR_POS);
      end
      return {sgn, mag};
   endfunction

endpackage

// File: rtl/quad_axis.sv
// One mouse axis: saturating signed accumulator, step decision on divider
// ticks, and a/b output encoder (quadrature or step/direction).
module quad_axis
   import ps2_quad_pkg::*;
#(
   parameter int ACC_W = 10,
   parameter int DW    = ACC_W + 3,
   parameter int MODE  = MODE_QUAD
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic signed [DW-1:0] delta,
   input  logic                 strobe,
   input  logic                 tick,
   output logic                 a,
   output logic                 b,
   output logic                 nonzero
);

   // One bit above the delta so acc + delta - step can never wrap before clamping
   localparam int SW = DW + 1;
   localparam logic signed [SW-1:0] ACC_MAX = {{(SW - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
   localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;
   localparam logic signed [SW-1:0] ONE     = SW'(1);

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    a_q, a_d;
   logic                    b_q, b_d;
   step_e                   step;
   logic signed [SW-1:0]    sum;

   // Step decision uses the registered accumulator, before this cycle's delta
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      step = STEP_NONE;
      if (tick && (acc_q != '0)) begin
         step = acc_q[ACC_W-1] ? STEP_NEG : STEP_POS;
      end
   end

   // Accumulate delta and remove the emitted step, clamping instead of wrapping
   always_comb begin
      sum = SW'(acc_q);
      if (strobe) begin
         sum = sum + SW'(delta);
      end
      case (step)
         STEP_POS: sum = sum - ONE;
         STEP_NEG: sum = sum + ONE;
         default:  ;
      endcase
      if (sum > ACC_MAX) begin
         acc_d = ACC_MAX[ACC_W-1:0];
      end else if (sum < ACC_MIN) begin
         acc_d = ACC_MIN[ACC_W-1:0];
      end else begin
         acc_d = sum[ACC_W-1:0];
      end
   end

   // Output encoder: Gray sequence on {a,b} or step pulse plus held direction
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (MODE == MODE_STEPDIR) begin
         a_d = (step != STEP_NONE);
         if (step != STEP_NONE) begin
            b_d = (step == STEP_NEG);
         end
      end else begin
         case (step)
            STEP_POS: begin a_d = ~b_q; b_d = a_q;  end
            STEP_NEG: begin a_d = b_q;  b_d = ~a_q; end
            default:  ;
         endcase
      end
   end

   // Axis state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         a_q   <= 1'b0;
         b_q   <= 1'b0;
      end else begin
         acc_q <= acc_d;
         a_q   <= a_d;
         b_q   <= b_d;
      end
   end

   assign a       = a_q;
   assign b       = b_q;
   assign nonzero = (acc_q != '0);

endmodule

// File: rtl/ps2_quad_mouse.sv
// PS/2 mouse packet to per-axis encoder emulator: packet strobe detection,
// flush divider, delta decode/scaling and button latch; axes in quad_axis.
module ps2_quad_mouse
   import ps2_quad_pkg::*;
#(
   parameter int ACC_W          = 10,
   parameter int DIV_W          = 12,
   parameter int SCALE          = 0,
   parameter int INVERT_Y       = 0,
   parameter int MODE           = MODE_QUAD,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce,
   input  logic [24:0] ps2_mouse,
   output logic        x_a,
   output logic        x_b,
   output logic        y_a,
   output logic        y_b,
   output logic [2:0]  btn,
   output logic        busy
);

   // Extra headroom so a negated -256 scaled by 8 is still representable
   localparam int         DW      = ACC_W + 3;
   localparam logic [2:0] BTN_RST = (BTN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

   logic                 old_stb_q;
   logic                 strobe;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 tick;
   logic [2:0]           btn_q, btn_d;
   logic [7:0]           status;
   logic signed [8:0]    raw_x, raw_y;
   logic signed [DW-1:0] dx, dy;
   logic                 x_nz, y_nz;
   logic                 unused_status;

   assign status        = ps2_mouse[7:0];
   assign unused_status = status[ST_ONE];
   assign strobe        = ps2_mouse[24] ^ old_stb_q;
   assign tick          = ce && (div_q == '0);

   // Decode both deltas: overflow clamp, optional Y inversion, then scaling
   always_comb begin
      raw_x = decode_delta(status[ST_XSGN], status[ST_XOVR], ps2_mouse[15:8]);
      raw_y = decode_delta(status[ST_YSGN], status[ST_YOVR], ps2_mouse[23:16]);
      dx    = DW'(raw_x) <<< SCALE;
      dy    = DW'(raw_y);
      if (INVERT_Y != 0) begin
         dy = -dy;
      end
      dy = dy <<< SCALE;
   end

   // Free-running flush divider and button latch next state
   always_comb begin
      div_d = div_q;
      btn_d = btn_q;
      if (ce) begin
         div_d = div_q + DIV_W'(1);
      end
      if (strobe) begin
         btn_d = (BTN_ACTIVE_LOW != 0) ? ~status[2:0] : status[2:0];
      end
   end

   // Strobe history, divider and button registers
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         old_stb_q <= 1'b0;
         div_q     <= '0;
         btn_q     <= BTN_RST;
      end else begin
         old_stb_q <= ps2_mouse[24];
         div_q     <= div_d;
         btn_q     <= btn_d;
      end
   end

   quad_axis #(
      .ACC_W (ACC_W),
      .DW    (DW),
      .MODE  (MODE)
   ) u_axis_x (
      .clk     (clk),
      .reset_n (reset_n),
      .delta   (dx),
      .strobe  (strobe),
      .tick    (tick),
      .a       (x_a),
      .b       (x_b),
      .nonzero (x_nz)
   );

   quad_axis #(
      .ACC_W (ACC_W),
      .DW    (DW),
      .MODE  (MODE)
   ) u_axis_y (
      .clk     (clk),
      .reset_n (reset_n),
      .delta   (dy),
      .strobe  (strobe),
      .tick    (tick),
      .a       (y_a),
      .b       (y_b),
      .nonzero (y_nz)
   );

   assign btn  = btn_q;
   assign busy = x_nz | y_nz;

endmodule

// File: tb/tb_ps2_quad_mouse.sv
// Scoreboard bench for ps2_quad_mouse: four differently configured instances
// share one packet bus; an integer reference model queues expected steps and
// a negedge monitor pops them as the encoders move.
module tb_ps2_quad_mouse;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        ce = 1'b1;
   logic [24:0] ps2_mouse = '0;

   logic [3:0]  xa_w, xb_w, ya_w, yb_w, busy_w;
   logic [2:0]  btn_w [4];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         stream;
      int         cyc;
      logic [1:0] ab;
   } ev_t;

   ev_t evq[$];

   // Reference model state
   int         cyc = 0;
   int         m_div = 0;
   logic       m_old = 1'b0;
   int         m_acc [4][2];
   int         m_ph  [4][2];
   logic [2:0] m_btn [4];
   logic [1:0] prev  [8];

   always #5 clk = ~clk;

   // Instance configurations: 0 default quad, 1 scaled+inverted, 2 step/dir, 3 wide active-high
   ps2_quad_mouse #(.ACC_W(10), .DIV_W(4), .SCALE(0), .INVERT_Y(0), .MODE(0), .BTN_ACTIVE_LOW(1)) u0 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .ps2_mouse(ps2_mouse),
      .x_a(xa_w[0]), .x_b(xb_w[0]), .y_a(ya_w[0]), .y_b(yb_w[0]), .btn(btn_w[0]), .busy(busy_w[0]));
   ps2_quad_mouse #(.ACC_W(10), .DIV_W(4), .SCALE(2), .INVERT_Y(1), .MODE(0), .BTN_ACTIVE_LOW(1)) u1 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .ps2_mouse(ps2_mouse),
      .x_a(xa_w[1]), .x_b(xb_w[1]), .y_a(ya_w[1]), .y_b(yb_w[1]), .btn(btn_w[1]), .busy(busy_w[1]));
   ps2_quad_mouse #(.ACC_W(10), .DIV_W(4), .SCALE(0), .INVERT_Y(0), .MODE(1), .BTN_ACTIVE_LOW(1)) u2 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .ps2_mouse(ps2_mouse),
      .x_a(xa_w[2]), .x_b(xb_w[2]), .y_a(ya_w[2]), .y_b(yb_w[2]), .btn(btn_w[2]), .busy(busy_w[2]));
   ps2_quad_mouse #(.ACC_W(12), .DIV_W(4), .SCALE(1), .INVERT_Y(0), .MODE(0), .BTN_ACTIVE_LOW(0)) u3 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .ps2_mouse(ps2_mouse),
      .x_a(xa_w[3]), .x_b(xb_w[3]), .y_a(ya_w[3]), .y_b(yb_w[3]), .btn(btn_w[3]), .busy(busy_w[3]));

   function automatic int cfg_accw(int k);  return (k == 3) ? 12 : 10; endfunction
   function automatic int cfg_scale(int k); return (k == 1) ? 2 : ((k == 3) ? 1 : 0); endfunction
   function automatic bit cfg_inv(int k);   return (k == 1); endfunction
   function automatic bit cfg_sd(int k);    return (k == 2); endfunction
   function automatic bit cfg_bal(int k);   return (k != 3); endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Packet delta in plain integers, straight from the packet rules
   function automatic int model_delta(int k, int ax, logic [24:0] p);
      int   v;
      int   mag;
      logic sgn, ovr;
      mag = (ax == 0) ? int'(p[15:8]) : int'(p[23:16]);
      sgn = (ax == 0) ? p[4] : p[5];
      ovr = (ax == 0) ? p[6] : p[7];
      if (ovr) v = sgn ? -256 : 255;
      else     v = sgn ? mag - 256 : mag;
      if (ax == 1 && cfg_inv(k)) v = -v;
      return v * (1 << cfg_scale(k));
   endfunction

   function automatic int clamp(int v, int k);
      int lim = 1 << (cfg_accw(k) - 1);
      if (v > lim - 1) return lim - 1;
      if (v < -lim)    return -lim;
      return v;
   endfunction

   // {a,b} for quadrature phase index 0..3
   function automatic logic [1:0] quad_ab(int ph);
      case (ph)
         0: return 2'b00;
         1: return 2'b10;
         2: return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic model_reset();
      m_old = 1'b0;
      m_div = 0;
      for (int k = 0; k < 4; k++) begin
         m_btn[k] = cfg_bal(k) ? 3'b111 : 3'b000;
         for (int ax = 0; ax < 2; ax++) begin
            m_acc[k][ax] = 0;
            m_ph[k][ax]  = 0;
         end
      end
   endtask

   task automatic model_step();
      bit strobe, tick;
      int st, d;
      ev_t e;
      cyc++;
      strobe = (ps2_mouse[24] != m_old);
      tick   = ce && (m_div == 0);
      for (int k = 0; k < 4; k++) begin
         for (int ax = 0; ax < 2; ax++) begin
            st = (tick && m_acc[k][ax] != 0) ? ((m_acc[k][ax] > 0) ? 1 : -1) : 0;
            d  = strobe ? model_delta(k, ax, ps2_mouse) : 0;
            m_acc[k][ax] = clamp(m_acc[k][ax] + d - st, k);
            if (st != 0) begin
               e.stream = k * 2 + ax;
               e.cyc    = cyc;
               if (cfg_sd(k)) begin
                  e.ab = {1'b1, (st < 0)};
               end else begin
                  m_ph[k][ax] = (m_ph[k][ax] + st + 4) % 4;
                  e.ab = quad_ab(m_ph[k][ax]);
               end
               evq.push_back(e);
            end
         end
         if (strobe) m_btn[k] = cfg_bal(k) ? ~ps2_mouse[2:0] : ps2_mouse[2:0];
      end
      m_old = ps2_mouse[24];
      if (ce) m_div = (m_div + 1) % 16;
   endtask

   task automatic monitor_reset();
      for (int s = 0; s < 8; s++) prev[s] = 2'b00;
   endtask

   task automatic monitor_step();
      ev_t        e;
      logic [1:0] ab;
      bit         ev;
      int         s;
      for (int k = 0; k < 4; k++) begin
         for (int ax = 0; ax < 2; ax++) begin
            s  = k * 2 + ax;
            ab = (ax == 0) ? {xa_w[k], xb_w[k]} : {ya_w[k], yb_w[k]};
            if (cfg_sd(k)) begin
               ev = ab[1];
               if (!ab[1]) check($sformatf("dir hold u%0d ax%0d", k, ax), ab[0], prev[s][0]);
            end else begin
               ev = (ab != prev[s]);
            end
            if (ev) begin
               check($sformatf("step expected u%0d ax%0d", k, ax), int'(evq.size() != 0), 1);
               if (evq.size() != 0) begin
                  e = evq.pop_front();
                  check($sformatf("step stream u%0d ax%0d", k, ax), s, e.stream);
                  check($sformatf("step cycle u%0d ax%0d", k, ax), cyc, e.cyc);
                  check($sformatf("step ab u%0d ax%0d", k, ax), int'(ab), int'(e.ab));
               end
            end
            prev[s] = ab;
         end
         check($sformatf("busy u%0d", k), busy_w[k],
               int'(m_acc[k][0] != 0 || m_acc[k][1] != 0));
         check($sformatf("btn u%0d", k), btn_w[k], m_btn[k]);
      end
   endtask

   // Reference model runs on the same edges as the design
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step();
   end

   // Monitor samples on the falling edge, away from the active edge
   always @(negedge clk or negedge reset_n) begin
      if (!reset_n) monitor_reset();
      else          monitor_step();
   end

   task automatic check_reset();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("reset x_a u%0d", k), xa_w[k], 0);
         check($sformatf("reset x_b u%0d", k), xb_w[k], 0);
         check($sformatf("reset y_a u%0d", k), ya_w[k], 0);
         check($sformatf("reset y_b u%0d", k), yb_w[k], 0);
         check($sformatf("reset busy u%0d", k), busy_w[k], 0);
         check($sformatf("reset btn u%0d", k), btn_w[k], cfg_bal(k) ? 7 : 0);
      end
   endtask

   task automatic next_cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [7:0] st, input logic [7:0] x, input logic [7:0] y);
      ps2_mouse = {~ps2_mouse[24], y, x, st};
   endtask

   // Asynchronous reset asserted between edges and checked before any clock
   task automatic pulse_reset();
      @(negedge clk);
      #1;
      reset_n   = 1'b0;
      ps2_mouse = '0;
      #1;
      check_reset();
      #5;
      reset_n = 1'b1;
   endtask

   initial begin
      int         v;
      logic [7:0] xb, yb, st;
      // Packet with bit24 already set is waiting when reset releases: X = +3
      ps2_mouse = {1'b1, 8'h00, 8'h03, 8'h08};
      #1 reset_n = 1'b0;
      #20 check_reset();
      #7 reset_n = 1'b1;
      next_cycle(60);

      // Reverse X = -2
      send(8'h18, 8'hFE, 8'h00);
      next_cycle(50);

      // Three X = +100 packets drive the scaled instance into saturation
      for (int i = 0; i < 3; i++) begin
         send(8'h08, 8'd100, 8'h00);
         next_cycle(2);
      end
      next_cycle(10000);

      // X overflow (+255) and Y = +5, then left button
      send(8'h48, 8'h10, 8'h05);
      next_cycle(100);
      send(8'h09, 8'h00, 8'h00);
      next_cycle(5);
      pulse_reset();

      // Strobe of X = +1 coinciding with a tick while acc_x = 1
      next_cycle(4);
      send(8'h08, 8'h01, 8'h00);
      do next_cycle(1); while (m_div != 0);
      send(8'h08, 8'h01, 8'h00);
      next_cycle(4);
      check("busy after coincident step", busy_w[0], 1);
      pulse_reset();
      next_cycle(3);

      // Random packets with small deltas, occasional overflow, gated ce
      for (int i = 0; i < 40; i++) begin
         v  = int'($urandom_range(0, 40)) - 20;
         xb = v[7:0];
         st = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'b0, (v < 0),
               1'b1, 3'($urandom_range(0, 7))};
         v  = int'($urandom_range(0, 40)) - 20;
         yb = v[7:0];
         st[5] = (v < 0);
         send(st, xb, yb);
         repeat ($urandom_range(1, 30)) begin
            next_cycle(1);
            ce = ($urandom_range(0, 3) != 0);
         end
      end
      ce = 1'b1;
      next_cycle(20);
      @(negedge clk);
      #1;
      check("steps left in queue", evq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
